// File: rtl/mux_stream_rr_pkg.sv
// Shared constants and helpers for the round-robin streaming multiplexer.
package mux_stream_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2, used to size channel indices (value >= 2 in practice).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_stream_rr_if.sv
// Handshake bundle between the per-channel producers, the mux and the consumer.
interface mux_stream_rr_if #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 8
) ();
    import mux_stream_pkg::*;

    localparam int SEL_W = clog2(NUM_CH);

    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_valid;
    logic                     out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

endinterface

// File: rtl/mux_stream_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester strictly
// above ptr, otherwise wraps around to the first requester at or below ptr.
module rr_arbiter_n import mux_stream_pkg::*; #(
    parameter  int NUM_CH = 8,
    localparam int SEL_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              any_grant
);

    logic             hi_found;
    logic             lo_found;
    logic [SEL_W-1:0] hi_idx;
    logic [SEL_W-1:0] lo_idx;

    // Lowest requester above the pointer and lowest requester at/below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req[i] && (SEL_W'(i) > ptr) && !hi_found) begin
                hi_found = 1'b1;
                hi_idx   = SEL_W'(i);
            end
            if (req[i] && (SEL_W'(i) <= ptr) && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = SEL_W'(i);
            end
        end
    end

    // Upper half wins, which gives the wrap from NUM_CH-1 back to 0.
    always_comb begin
        any_grant = hi_found || lo_found;
        grant_idx = hi_found ? hi_idx : lo_idx;
        grant     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            grant[i] = any_grant && (grant_idx == SEL_W'(i));
        end
    end

endmodule

// File: rtl/mux_stream_rr.sv
// N:1 valid/ready stream mux with fixed-select and round-robin modes and a
// single registered output stage (1-cycle latency, full throughput).
module mux_stream_rr import mux_stream_pkg::*; #(
    parameter  int NUM_CH = 8,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_stream_rr_if.slave    bus,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel
);

    logic              load_en;
    logic [NUM_CH-1:0] fix_grant;
    logic [NUM_CH-1:0] arb_grant;
    logic [SEL_W-1:0]  arb_idx;
    logic              arb_any;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              any_grant;
    logic [DATA_W-1:0] grant_data;
    logic [SEL_W-1:0]  rr_ptr;

    // The output register can accept a word when empty or draining this cycle.
    assign load_en = !bus.out_valid || bus.out_ready;

    // Fixed select: an out-of-range sel matches no channel, so it grants nothing.
    always_comb begin
        fix_grant = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            fix_grant[i] = bus.in_valid[i] && (sel == SEL_W'(i));
        end
    end

    rr_arbiter_n #(.NUM_CH(NUM_CH)) u_arb (
        .req       (bus.in_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    // Mode decides which grant source is live this cycle.
    always_comb begin
        if (mode == MODE_RR) begin
            grant     = arb_grant;
            grant_idx = arb_idx;
        end else begin
            grant     = fix_grant;
            grant_idx = sel;
        end
    end

    assign any_grant = |grant;

    // Ready is held low during reset so no producer sees a phantom accept.
    assign bus.in_ready = (rst_n && load_en) ? grant : '0;

    // AND-OR payload mux keyed on the one-hot grant; ready never depends on data.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                grant_data = grant_data | bus.in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Output stage: load on transfer, go empty when free with nothing granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
        end else if (load_en) begin
            bus.out_valid <= any_grant;
            if (any_grant) begin
                bus.out_data <= grant_data;
                bus.out_ch   <= grant_idx;
            end
        end
    end

    // Round-robin pointer follows the last channel served in round-robin mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= SEL_W'(NUM_CH - 1);
        end else if (load_en && any_grant && (mode == MODE_RR)) begin
            rr_ptr <= grant_idx;
        end
    end

endmodule
